// File: rtl/pattern_det.sv
// Purpose: Moore detector flagging every overlapping occurrence of serial pattern 1-0-1-1-0.
// Latency: pattern rises just after the edge that accepts the final '0' and holds until the next accepted bit.
// Backpressure: none; valid_i low freezes the FSM, so pattern holds through gaps.
module pattern_det (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    input  logic valid_i,
    output logic pattern
);

    // Binary encoding; codes 6 and 7 are unreachable and recover to IDLE.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        S1    = 3'd1,
        S10   = 3'd2,
        S101  = 3'd3,
        S1011 = 3'd4,
        DET   = 3'd5
    } state_t;

    state_t state;
    state_t state_nxt;

    // State register with synchronous reset that overrides data and valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: longest suffix of accepted bits that is a prefix of 10110.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (valid_i) begin
                    state_nxt = d_i ? S1 : IDLE;
                end
            end
            S1: begin
                if (valid_i) begin
                    state_nxt = d_i ? S1 : S10;
                end
            end
            S10: begin
                if (valid_i) begin
                    state_nxt = d_i ? S101 : IDLE;
                end
            end
            S101: begin
                // "1010" still ends in the prefix "10".
                if (valid_i) begin
                    state_nxt = d_i ? S1011 : S10;
                end
            end
            S1011: begin
                // "10111" only keeps the trailing "1".
                if (valid_i) begin
                    state_nxt = d_i ? S1 : DET;
                end
            end
            DET: begin
                // A following '1' reuses the trailing "10" of the match.
                if (valid_i) begin
                    state_nxt = d_i ? S101 : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output is a pure decode of the state register; no input terms.
    always_comb begin
        pattern = (state == DET);
    end

endmodule

// File: tb/tb_pattern_det.sv
module tb_pattern_det;

    logic clk;
    logic rst;
    logic d_i;
    logic valid_i;
    logic pattern;

    int checks;
    int failures;
    int rises;
    logic prev_pat;

    // Reference: last five accepted bits, newest in bit 0.
    logic [4:0] hist;
    logic       exp_pat;

    logic soak_bits [540];
    int   exp_soak;

    pattern_det dut (
        .clk     (clk),
        .rst     (rst),
        .d_i     (d_i),
        .valid_i (valid_i),
        .pattern (pattern)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
            $error("%s mismatch", tag);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("%s mismatch", tag);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, check after it.
    task automatic step(input logic r, input logic v, input logic d, input string tag);
        rst     = r;
        valid_i = v;
        d_i     = d;
        @(posedge clk);
        if (r) begin
            hist = 5'b0;
        end else if (v) begin
            hist = {hist[3:0], d};
        end
        exp_pat = (hist == 5'b10110);
        #1;
        check_bit(tag, pattern, exp_pat);
        if (pattern && !prev_pat) rises++;
        prev_pat = pattern;
    endtask

    task automatic feed(input logic [15:0] bits, input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b0, 1'b1, bits[i], tag);
        end
    endtask

    initial begin
        logic [15:0] seq;
        checks   = 0;
        failures = 0;
        rises    = 0;
        prev_pat = 1'b0;
        hist     = 5'b0;
        rst      = 1'b1;
        valid_i  = 1'b0;
        d_i      = 1'b0;

        // Reset with unknown data and valid.
        step(1'b1, 1'bx, 1'bx, "reset0");
        step(1'b1, 1'bx, 1'bx, "reset1");
        check_bit("reset_pat", pattern, 1'b0);
        // "0110" directly after reset must not match: proves IDLE start.
        feed(16'b0110, 4, "post_reset");
        check_int("post_reset_rises", rises, 0);

        // Single match followed by a trailing 0.
        step(1'b1, 1'b0, 1'b0, "rst_a");
        rises = 0;
        feed(16'b101100, 6, "single");
        check_int("single_rises", rises, 1);

        // Overlapping back-to-back matches.
        step(1'b1, 1'b0, 1'b0, "rst_b");
        rises = 0;
        seq = 16'b10110110;
        for (int i = 7; i >= 0; i--) begin
            step(1'b0, 1'b1, seq[i], "overlap");
            if (i == 3) check_bit("overlap_first", pattern, 1'b1);
            if (i == 2) check_bit("overlap_gap", pattern, 1'b0);
        end
        check_bit("overlap_second", pattern, 1'b1);
        check_int("overlap_rises", rises, 2);

        // Valid gaps between bits and a trailing gap.
        step(1'b1, 1'b0, 1'b0, "rst_c");
        rises = 0;
        seq = 16'b10110;
        for (int i = 4; i >= 0; i--) begin
            step(1'b0, 1'b1, seq[i], "gap_bit");
            step(1'b0, 1'b0, ~seq[i], "gap_idle");
            step(1'b0, 1'b0, seq[i], "gap_idle");
        end
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, "gap_tail");
        check_bit("gap_hold", pattern, 1'b1);
        step(1'b0, 1'b1, 1'b0, "gap_drop");
        check_bit("gap_dropped", pattern, 1'b0);
        check_int("gap_rises", rises, 1);

        // Non-matching runs and reset mid-sequence.
        rises = 0;
        feed(16'b1111, 4, "ones");
        feed(16'b0000, 4, "zeros");
        feed(16'b1011, 4, "partial");
        step(1'b1, 1'b1, 1'b0, "mid_rst");
        step(1'b0, 1'b1, 1'b0, "after_rst");
        check_int("nomatch_rises", rises, 0);

        // Random soak against an occurrence count over the whole stream.
        step(1'b1, 1'b0, 1'b0, "rst_d");
        rises = 0;
        for (int i = 0; i < 540; i++) soak_bits[i] = 1'($urandom_range(1, 0));
        exp_soak = 0;
        for (int i = 4; i < 540; i++) begin
            if (soak_bits[i-4] && !soak_bits[i-3] && soak_bits[i-2] &&
                soak_bits[i-1] && !soak_bits[i]) exp_soak++;
        end
        for (int i = 0; i < 540; i++) step(1'b0, 1'b1, soak_bits[i], "soak");
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0, "soak_tail");
        check_int("soak_rises", rises, exp_soak);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pattern_det.md
# pattern_det

Serial Moore-type sequence detector that watches a 1-bit data stream qualified by a valid strobe and flags every occurrence of the bit pattern 1-0-1-1-0, first bit first. Overlapping occurrences are detected. The output is a registered state decode, so it depends only on the current state and never combinationally on the inputs. It is a self-contained leaf block for pattern-spotting on serial links and for event counting in test environments.

## Interface
- No parameters. The pattern 10110 is fixed.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `d_i` input, 1 bit: serial data bit, sampled on the rising edge of `clk` when `valid_i`=1.
- `valid_i` input, 1 bit: data qualifier. When low, `d_i` is ignored and the state holds.
- `pattern` output, 1 bit: high while the FSM is in state DET, i.e. the last five accepted bits were 1,0,1,1,0.
- Port order for positional instantiation: `clk`, `rst`, `d_i`, `valid_i`, `pattern`.

## Operation
- Moore FSM with six states. Encoding is free; one-hot or 3-bit binary are both acceptable.
  - IDLE: no useful prefix.
  - S1: prefix "1".
  - S10: prefix "10".
  - S101: prefix "101".
  - S1011: prefix "1011".
  - DET: full match "10110".
- Transitions, applied only on a rising edge with `valid_i`=1. The next state is the longest suffix of the accepted bits that is also a prefix of the pattern.
  - IDLE: d=1 goes to S1; d=0 goes to IDLE.
  - S1: d=0 goes to S10; d=1 goes to S1.
  - S10: d=1 goes to S101; d=0 goes to IDLE.
  - S101: d=1 goes to S1011; d=0 goes to S10 (suffix "10" of "1010").
  - S1011: d=0 goes to DET; d=1 goes to S1 (suffix "1" of "10111").
  - DET: d=1 goes to S101 (overlap through "10"); d=0 goes to IDLE.
- `valid_i`=0 leaves the state unchanged, including DET, so `pattern` stays high through valid gaps until the next accepted bit.
- `pattern` = (state == DET). Decode it from the state register only, with no input terms. Registering the decode is also allowed, provided the timing below holds exactly.
- Unreachable or illegal encodings must return to IDLE on the next clock.

## Timing
- Reset: while `rst`=1 at a rising edge, the state goes to IDLE and `pattern`=0 after that edge. `rst` overrides `valid_i` and `d_i`, and both may be X during reset.
- Reset mid-sequence discards any partial match. Detection restarts from IDLE on the first accepted bit after `rst` is released.
- Latency: the final '0' of a match is sampled at edge N, and `pattern` is high from just after edge N until just after the next edge at which a bit is accepted.
- With `valid_i` held at 1, each match gives a pattern pulse exactly one clock wide.
- Back-to-back overlapping matches, as in "10110110", give two separate one-cycle pulses three accepted bits apart. `pattern` returns low between them.
- There are no combinational paths from inputs to `pattern`.

## Test plan
- Reset behaviour:
  - Stimulus: hold `rst`=1 for 2 cycles with `d_i`/`valid_i`=X, then release.
  - Required response: `pattern`=0 throughout and state is IDLE.
- Single match:
  - Stimulus: `valid_i`=1 and `d_i`=1,0,1,1,0,0.
  - Required response: `pattern` is high only in the cycle after the 5th bit; exactly one rising edge.
- Overlap:
  - Stimulus: `d_i`=1,0,1,1,0,1,1,0 with `valid_i`=1.
  - Required response: pulses after bit 5 and after bit 8; a posedge counter reads 2.
- Valid gaps:
  - Stimulus: 1,0,1,1,0 with `valid_i`=0 cycles inserted between bits and after the last bit.
  - Required response: one detection; `pattern` stays high across the trailing gap and drops after the next accepted bit.
- Non-matches and mid-sequence reset:
  - Stimulus: 1,1,1,1 and 0,0,0,0 give no pulse. Then 1,0,1,1, then `rst` for 1 cycle, then 0.
  - Required response: no pulse in any of these cases.
- Random soak:
  - Stimulus: 540 random bits with `valid_i`=1, then `valid_i`=0 for 5 cycles.
  - Required response: the number of `pattern` rising edges equals a reference-model count of overlapping "10110" occurrences.
